// File: rtl/mioc_pkg.sv
// Shared constants and sizing helper for the mioc input conditioning stage.
package mioc_pkg;

    localparam int unsigned MIOC_SYNC_STAGES_DEF = 2;
    localparam int unsigned MIOC_FILT_CYC_DEF    = 4;
    localparam int unsigned MIOC_IN_W            = 4;
    localparam int unsigned MIOC_CNT_W_DEF       = 8;

    // Smallest counter width W with 2**W > filt_cyc.
    function automatic int unsigned mioc_cnt_w(input int unsigned filt_cyc);
        return $clog2(filt_cyc + 1);
    endfunction

endpackage

// File: rtl/mioc_bit_filter.sv
// One input bit: synchronizer chain followed by a stability filter that only
// passes levels held for FILT_CYC consecutive clocks.
module mioc_bit_filter
    import mioc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = MIOC_SYNC_STAGES_DEF,
    parameter int unsigned FILT_CYC    = MIOC_FILT_CYC_DEF,
    parameter int unsigned CNT_W       = MIOC_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_i,
    output logic q_o,
    output logic upd_c_o,
    output logic idle_c_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_c;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   upd_c;

    // Plain flop chain, no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
        end
    end

    assign s_c = sync_q[SYNC_STAGES-1];

    // A disagreeing level must persist for FILT_CYC evaluations; any agreement
    // in between throws the partial count away.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        upd_c = 1'b0;
        if (s_c == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            q_d   = s_c;
            cnt_d = '0;
            upd_c = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q_o      = q_q;
    assign upd_c_o  = upd_c;
    assign idle_c_o = (s_c == q_q) && (cnt_q == '0);

endmodule

// File: rtl/mioc_in_filter.sv
// Conditions the four asynchronous gate inputs into clean levels, with a
// change strobe and a settled indication for downstream users of z.
module mioc_in_filter
    import mioc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = MIOC_SYNC_STAGES_DEF,
    parameter int unsigned FILT_CYC    = MIOC_FILT_CYC_DEF,
    parameter int unsigned CNT_W       = MIOC_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MIOC_IN_W-1:0] a_in,
    output logic [MIOC_IN_W-1:0] q,
    output logic                 chg,
    output logic                 stable
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_CYC < 1 || FILT_CYC > 255 ||
        CNT_W < mioc_cnt_w(FILT_CYC)) begin : g_bad_params
        $error("mioc_in_filter: illegal parameter combination");
    end

    logic [MIOC_IN_W-1:0] upd_c;
    logic [MIOC_IN_W-1:0] idle_c;
    logic                 chg_q;

    for (genvar i = 0; i < MIOC_IN_W; i++) begin : g_bit
        mioc_bit_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYC   (FILT_CYC),
            .CNT_W      (CNT_W)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .a_i     (a_in[i]),
            .q_o     (q[i]),
            .upd_c_o (upd_c[i]),
            .idle_c_o(idle_c[i])
        );
    end

    // Registered on the same edge as q so the pulse lines up with the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= |upd_c;
        end
    end

    assign chg    = chg_q;
    assign stable = &idle_c;

endmodule

// File: tb/tb_mioc_in_filter.sv
// Bench for mioc_in_filter: default instance plus a SYNC_STAGES=3/FILT_CYC=1
// instance, both checked against a run-length reference model.
module tb_mioc_in_filter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a_in  = 4'b0000;
    logic [3:0] q, q2;
    logic       chg, chg2, stable, stable2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mioc_in_filter dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .q(q), .chg(chg), .stable(stable)
    );

    mioc_in_filter #(.SYNC_STAGES(3), .FILT_CYC(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .q(q2), .chg(chg2), .stable(stable2)
    );

    // Reference model: history of sampled inputs (index 0 = newest) and, per
    // bit, how many consecutive evaluations the synchronized level has
    // disagreed with the filtered output.
    logic [3:0] hist[$];
    logic [3:0] m_q[2];
    logic       m_chg[2];
    int         m_run[2][4];

    function automatic int sync_of(input int inst);
        return (inst == 0) ? 2 : 3;
    endfunction

    function automatic int filt_of(input int inst);
        return (inst == 0) ? 4 : 1;
    endfunction

    function automatic logic [3:0] hist_at(input int k);
        return (hist.size() > k) ? hist[k] : 4'b0000;
    endfunction

    function automatic logic m_stable(input int inst);
        logic [3:0] s;
        s = hist_at(sync_of(inst) - 1);
        for (int b = 0; b < 4; b++)
            if (s[b] !== m_q[inst][b] || m_run[inst][b] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int n = 0; n < 2; n++) begin
            m_q[n]   = 4'b0000;
            m_chg[n] = 1'b0;
            for (int b = 0; b < 4; b++) m_run[n][b] = 0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] s_pre;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hist.push_front(a_in);
        if (hist.size() > 8) void'(hist.pop_back());
        for (int n = 0; n < 2; n++) begin
            s_pre    = hist_at(sync_of(n));
            m_chg[n] = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (s_pre[b] == m_q[n][b]) begin
                    m_run[n][b] = 0;
                end else if (m_run[n][b] + 1 >= filt_of(n)) begin
                    m_q[n][b]   = s_pre[b];
                    m_run[n][b] = 0;
                    m_chg[n]    = 1'b1;
                end else begin
                    m_run[n][b] = m_run[n][b] + 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        a_in = 4'b0000;
        repeat (10) step();
    endtask

    task automatic test_reset();
        int rise_e = -1;
        int pulses = 0;
        rst_n = 1'b0;
        a_in  = 4'b1111;
        model_reset();
        repeat (5) step();
        n_checks++;
        if (q !== 4'b0000 || chg !== 1'b0 || stable !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_hold got q=%b chg=%b stable=%b want q=0000 chg=0 stable=1", q, chg, stable);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (chg) pulses++;
            if (q == 4'b1111 && rise_e < 0) rise_e = e;
            n_checks++;
            if (stable !== ((e >= 2 && e <= 5) ? 1'b0 : 1'b1) ||
                {q, chg, stable} !== {m_q[0], m_chg[0], m_stable(0)}) begin
                n_errors++;
                $display("FAIL reset_release e=%0d got q=%b chg=%b stable=%b want q=%b chg=%b stable=%b",
                         e, q, chg, stable, m_q[0], m_chg[0], m_stable(0));
            end
        end
        n_checks++;
        if (rise_e != 6 || pulses != 1) begin
            n_errors++;
            $display("FAIL reset_latency got edge=%0d pulses=%0d want edge=6 pulses=1", rise_e, pulses);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        bit dipped = 1'b0;
        settle();
        a_in = 4'b0100;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e == 3) a_in = 4'b0000;
            if (chg) pulses++;
            if (!stable) dipped = 1'b1;
            n_checks++;
            if (q !== 4'b0000 || {q, chg, stable} !== {m_q[0], m_chg[0], m_stable(0)}) begin
                n_errors++;
                $display("FAIL glitch e=%0d got q=%b chg=%b stable=%b want q=%b chg=%b stable=%b",
                         e, q, chg, stable, m_q[0], m_chg[0], m_stable(0));
            end
        end
        n_checks++;
        if (pulses != 0 || !dipped || stable !== 1'b1) begin
            n_errors++;
            $display("FAIL glitch_summary got pulses=%0d dipped=%0d stable=%b want 0 1 1", pulses, dipped, stable);
        end
    endtask

    task automatic test_threshold();
        int rise_e = -1;
        int fall_e = -1;
        int pulses = 0;
        settle();
        a_in = 4'b0001;
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e == 4) a_in = 4'b0000;
            if (chg) pulses++;
            if (q[0] && rise_e < 0) rise_e = e;
            if (!q[0] && rise_e > 0 && fall_e < 0) fall_e = e;
            n_checks++;
            if ({q, chg, stable} !== {m_q[0], m_chg[0], m_stable(0)}) begin
                n_errors++;
                $display("FAIL threshold e=%0d got q=%b chg=%b stable=%b want q=%b chg=%b stable=%b",
                         e, q, chg, stable, m_q[0], m_chg[0], m_stable(0));
            end
        end
        n_checks++;
        if (rise_e != 6 || fall_e != 10 || pulses != 2) begin
            n_errors++;
            $display("FAIL threshold_timing got rise=%0d fall=%0d pulses=%0d want rise=6 fall=10 pulses=2",
                     rise_e, fall_e, pulses);
        end
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        settle();
        a_in = 4'b0101;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (chg) pulses++;
            n_checks++;
            if (q !== ((e >= 6) ? 4'b0101 : 4'b0000) ||
                {q, chg, stable} !== {m_q[0], m_chg[0], m_stable(0)}) begin
                n_errors++;
                $display("FAIL simultaneous e=%0d got q=%b chg=%b stable=%b want q=%b chg=%b stable=%b",
                         e, q, chg, stable, m_q[0], m_chg[0], m_stable(0));
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL simultaneous_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_reversal();
        settle();
        a_in = 4'b1000;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 2) a_in = 4'b0000;
            if (e == 3) a_in = 4'b1000;
            n_checks++;
            if (q[3] !== ((e >= 9) ? 1'b1 : 1'b0) ||
                {q, chg, stable} !== {m_q[0], m_chg[0], m_stable(0)}) begin
                n_errors++;
                $display("FAIL reversal e=%0d got q=%b chg=%b stable=%b want q=%b chg=%b stable=%b",
                         e, q, chg, stable, m_q[0], m_chg[0], m_stable(0));
            end
        end
    endtask

    task automatic test_async_reset();
        int rise1 = -1;
        int rise2 = -1;
        settle();
        a_in = 4'b1010;
        repeat (8) step();
        a_in = 4'b0101;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (q !== 4'b0000 || chg !== 1'b0 || stable !== 1'b1 ||
            q2 !== 4'b0000 || chg2 !== 1'b0 || stable2 !== 1'b1) begin
            n_errors++;
            $display("FAIL async_reset got q=%b chg=%b stable=%b q2=%b chg2=%b stable2=%b want 0000 0 1 0000 0 1",
                     q, chg, stable, q2, chg2, stable2);
        end
        step();
        a_in  = 4'b1111;
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (q == 4'b1111 && rise1 < 0) rise1 = e;
            if (q2 == 4'b1111 && rise2 < 0) rise2 = e;
            n_checks++;
            if ({q, chg, stable, q2, chg2, stable2} !==
                {m_q[0], m_chg[0], m_stable(0), m_q[1], m_chg[1], m_stable(1)}) begin
                n_errors++;
                $display("FAIL async_release e=%0d got %b/%b/%b %b/%b/%b want %b/%b/%b %b/%b/%b", e,
                         q, chg, stable, q2, chg2, stable2,
                         m_q[0], m_chg[0], m_stable(0), m_q[1], m_chg[1], m_stable(1));
            end
        end
        n_checks++;
        if (rise1 != 6 || rise2 != 4) begin
            n_errors++;
            $display("FAIL async_latency got default=%0d fast=%0d want default=6 fast=4", rise1, rise2);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        settle();
        for (int e = 0; e < 400; e++) begin
            if (hold == 0) begin
                a_in = 4'($urandom);
                hold = $urandom_range(1, 7);
            end
            hold--;
            step();
            n_checks++;
            if ({q, chg, stable, q2, chg2, stable2} !==
                {m_q[0], m_chg[0], m_stable(0), m_q[1], m_chg[1], m_stable(1)}) begin
                n_errors++;
                $display("FAIL random e=%0d got %b/%b/%b %b/%b/%b want %b/%b/%b %b/%b/%b", e,
                         q, chg, stable, q2, chg2, stable2,
                         m_q[0], m_chg[0], m_stable(0), m_q[1], m_chg[1], m_stable(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_threshold();
        test_simultaneous();
        test_reversal();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mioc_in_filter.md
Name: mioc_in_filter

Overview:
- Upstream conditioning stage for the nand4/nor2 open-drain gate model. Takes four asynchronous board-level inputs and delivers clean, glitch-free levels on in1..in4 of that gate.
- Each bit is first synchronized into the clock domain through a multi-flop chain. It then passes through a per-bit stability filter, so only levels held for FILT_CYC consecutive clocks propagate.
- Also provides a change strobe and a settled flag. Downstream logic uses these to know when the gate output z is meaningful.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per bit; legal range 2..4.
- FILT_CYC, 4, consecutive stable clocks required before the filtered level updates; legal range 1..255.
- CNT_W, 8, width of each per-bit stability counter; must satisfy 2**CNT_W > FILT_CYC.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_in  input  4  raw asynchronous inputs; bit0..bit3 map to in1..in4.
- q  output  4  filtered levels; q[0]..q[3] drive in1..in4 of the gate.
- chg  output  1  one-cycle pulse in the cycle any q bit takes a new value.
- stable  output  1  high when, for every bit, the synchronized level equals q and the counter is 0.

Behaviour:
- Reset: asynchronous assert and release on rst_n low. While low:
  - all synchronizer flops = 0
  - q = 4'b0000
  - all counters = 0
  - chg = 0
  - stable = 1
- Synchronizer: per bit, s[i] is the last flop of a SYNC_STAGES-deep chain fed by a_in[i]. No logic between flops.
- Filter, per bit, evaluated each rising edge:
  - s == q: cnt <= 0, q holds. Any partially counted glitch is discarded.
  - s != q and cnt < FILT_CYC-1: cnt <= cnt+1, q holds.
  - s != q and cnt == FILT_CYC-1: q <= s, cnt <= 0.
- FILT_CYC=1 degenerates to q <= s every cycle, i.e. one register after the synchronizer.
- Latency: a clean a_in transition sampled at edge t appears on q after exactly SYNC_STAGES+FILT_CYC rising edges. Default is 6 clocks.
- Glitch rejection: any a_in pulse whose synchronized width is shorter than FILT_CYC clocks never reaches q. A pulse of exactly FILT_CYC clocks does propagate.
- Reversal mid-count: the counter clears, and a full FILT_CYC window must restart from the reversal.
- chg is registered and high for exactly the one cycle in which q first shows its new value. Simultaneous updates on several bits in the same cycle produce a single chg pulse. Updates on consecutive cycles produce back-to-back pulses.
- stable is combinational from registered state only (s, q, cnt); it is never driven directly from a_in. It goes low the cycle a synchronized level first differs from q.
- Counters saturate by construction: the maximum count value is FILT_CYC-1, with no wrap.
- Reset mid-count: the counter and q are cleared immediately. After rst_n release, an input held at 1 needs SYNC_STAGES+FILT_CYC clocks to reach q.

Decomposition:
- Shared package mioc_pkg holds:
  - MIOC_SYNC_STAGES_DEF = 2
  - MIOC_FILT_CYC_DEF = 4
  - MIOC_IN_W = 4
  - a localparam helper for CNT_W sizing
- Sub-module mioc_bit_filter: one bit containing its synchronizer chain, counter, q flop and a local update strobe. It is instantiated MIOC_IN_W times.
- The top ORs the update strobes into chg and ANDs the per-bit idle flags into stable.

Test Plan:
- Reset: hold rst_n=0 with a_in=4'b1111 for 5 clocks -> q=0000, chg=0, stable=1. Release, then q=1111 exactly 6 clocks later with a single chg pulse. stable is low from 2 clocks after release until q updates.
- Glitch rejection, defaults: a_in[2] high for 3 clocks, then low -> q stays 0000, chg never asserts, stable dips low then returns to 1.
- Threshold: a_in[0] high for exactly 4 clocks -> q[0]=1 at 6 clocks after the rise, one chg pulse. The later fall likewise appears 6 clocks after it, with a second chg pulse.
- Simultaneous change: a_in 0000 -> 0101 in the same cycle -> q=0101 after 6 clocks with exactly one chg pulse.
- Mid-count reversal: a_in[3] high 2 clocks, low 1 clock, then high steady -> q[3] rises 6 clocks after the last rise, not earlier.
- Async reset mid-count: pulse rst_n low during an in-progress count -> q, chg and the counters clear without waiting for a clock edge. Repeat with FILT_CYC=1, SYNC_STAGES=3 and check a latency of 4 clocks.
